// File: rtl/vga_fx_pkg.sv
// Shared types and helpers for the VGA colour-effect blocks.
// Latency: none (types, constants and a combinational helper only).
// Backpressure: none; pixel data is streamed without flow control.
package vga_fx_pkg;

  // Fade controller states.
  typedef enum logic [1:0] {
    LIGHT      = 2'd0,
    FADE_DARK  = 2'd1,
    DARK       = 2'd2,
    FADE_LIGHT = 2'd3
  } fade_state_t;

  // Per-channel transform selection.
  localparam int FX_INVERT = 0;
  localparam int FX_DIM    = 1;

  // Widest colour channel the helper handles; callers zero-extend into it.
  localparam int FX_MAX_W = 16;

  // Invert gives |old - lvl|; dim gives old - lvl clamped at zero.
  function automatic logic [FX_MAX_W-1:0] chan_fx(
    input logic [FX_MAX_W-1:0] old,
    input logic [FX_MAX_W-1:0] lvl,
    input int                  mode
  );
    logic [FX_MAX_W-1:0] res;
    res = '0;
    if (old >= lvl) begin
      res = old - lvl;
    end else if (mode == FX_INVERT) begin
      res = lvl - old;
    end
    return res;
  endfunction

endpackage

// File: rtl/step_prescaler.sv
// Free-running divider producing one fade-step strobe every STEP_CYCLES clocks.
// Latency: tick is a decode of the count register, high on count == STEP_CYCLES-1.
// Backpressure: none; the counter never stalls.
module step_prescaler #(
  parameter int STEP_CYCLES = 2097152
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);

  localparam int CNT_W = (STEP_CYCLES > 2) ? $clog2(STEP_CYCLES) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(STEP_CYCLES - 1);

  logic [CNT_W-1:0] cnt;

  // Count 0..STEP_CYCLES-1 and wrap, independent of the fade state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (cnt == LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  assign tick = (cnt == LAST);

endmodule

// File: rtl/day_night_fader.sv
// Score-driven day/night colour fader between the pixel generator and VGA pins.
// Latency: 1 clk pixel-in to pixel-out; level is sampled with the input pixel.
// Backpressure: none; every pixel is transformed and registered each cycle.
module day_night_fader
  import vga_fx_pkg::*;
#(
  parameter int COLOR_W        = 4,
  parameter int SCORE_W        = 14,
  parameter int TRIGGER_PERIOD = 700,
  parameter int DARK_SPAN      = 150,
  parameter int STEP_CYCLES    = 2097152,
  parameter int MODE           = 0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [SCORE_W-1:0] game_score,
  input  logic               force_light,
  input  logic [COLOR_W-1:0] OldVgaRed,
  input  logic [COLOR_W-1:0] OldVgaGreen,
  input  logic [COLOR_W-1:0] OldVgaBlue,
  output logic [COLOR_W-1:0] NewVgaRed,
  output logic [COLOR_W-1:0] NewVgaGreen,
  output logic [COLOR_W-1:0] NewVgaBlue,
  output logic [COLOR_W-1:0] level,
  output logic               is_night
);

  localparam logic [COLOR_W-1:0] LEVEL_MAX = '1;
  localparam logic [SCORE_W-1:0] TRIG_P    = SCORE_W'(TRIGGER_PERIOD);
  localparam logic [SCORE_W:0]   SPAN      = (SCORE_W + 1)'(DARK_SPAN);

  fade_state_t        state, state_nx;
  logic [COLOR_W-1:0] level_nx;
  logic [SCORE_W-1:0] prev_score;
  logic [SCORE_W-1:0] dark_start, dark_start_nx;
  logic [SCORE_W:0]   elapsed;
  logic               tick;
  logic               trig;
  logic               expire;
  logic               restart;

  step_prescaler #(
    .STEP_CYCLES(STEP_CYCLES)
  ) u_step_prescaler (
    .clk (clk),
    .rst (rst),
    .tick(tick)
  );

  // One extra bit so a score below dark_start wraps to a large value
  // instead of aliasing a small one; restart covers that case anyway.
  assign elapsed = {1'b0, game_score} - {1'b0, dark_start};
  assign expire  = (elapsed >= SPAN);
  assign restart = force_light || (game_score < dark_start);

  // A night starts only on the cycle the score lands on a non-zero multiple.
  always_comb begin
    trig = (game_score != prev_score) &&
           ((game_score % TRIG_P) == '0) &&
           (game_score != '0);
  end

  // Fade controller: restart > trig > expire > tick.
  always_comb begin
    state_nx      = state;
    level_nx      = level;
    dark_start_nx = dark_start;
    case (state)
      LIGHT: begin
        // A pending restart holds the day until the score is back past dark_start.
        if (trig && !restart) begin
          state_nx      = FADE_DARK;
          dark_start_nx = game_score;
        end
      end
      FADE_DARK: begin
        if (restart) begin
          state_nx = FADE_LIGHT;
        end else if (trig) begin
          dark_start_nx = game_score;
        end else if (expire) begin
          state_nx = FADE_LIGHT;
        end else if (tick) begin
          // The tick spent at LEVEL_MAX is what moves us into DARK.
          if (level == LEVEL_MAX) begin
            state_nx = DARK;
          end else begin
            level_nx = level + 1'b1;
          end
        end
      end
      DARK: begin
        if (restart) begin
          state_nx = FADE_LIGHT;
        end else if (trig) begin
          dark_start_nx = game_score;
        end else if (expire) begin
          state_nx = FADE_LIGHT;
        end
      end
      FADE_LIGHT: begin
        // A new night mid-fade reverses direction from the current level.
        if (trig && !restart) begin
          state_nx      = FADE_DARK;
          dark_start_nx = game_score;
        end else if (tick) begin
          if (level == '0) begin
            state_nx = LIGHT;
          end else begin
            level_nx = level - 1'b1;
          end
        end
      end
      default: begin
        state_nx = LIGHT;
      end
    endcase
  end

  // Controller and score history registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= LIGHT;
      level      <= '0;
      prev_score <= '0;
      dark_start <= '0;
    end else begin
      state      <= state_nx;
      level      <= level_nx;
      prev_score <= game_score;
      dark_start <= dark_start_nx;
    end
  end

  // Registered pixel transform using the level current with the input pixel.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      NewVgaRed   <= '0;
      NewVgaGreen <= '0;
      NewVgaBlue  <= '0;
      is_night    <= 1'b0;
    end else begin
      NewVgaRed   <= COLOR_W'(chan_fx(FX_MAX_W'(OldVgaRed),   FX_MAX_W'(level), MODE));
      NewVgaGreen <= COLOR_W'(chan_fx(FX_MAX_W'(OldVgaGreen), FX_MAX_W'(level), MODE));
      NewVgaBlue  <= COLOR_W'(chan_fx(FX_MAX_W'(OldVgaBlue),  FX_MAX_W'(level), MODE));
      is_night    <= (state_nx == FADE_DARK) || (state_nx == DARK);
    end
  end

endmodule

// File: tb/tb_day_night_fader.sv
// Directed bench for day_night_fader: invert and dim instances share stimulus.
// Latency: checks sample on the falling edge, one rising edge after driving.
// Backpressure: not applicable.
module tb_day_night_fader;
  import vga_fx_pkg::*;

  localparam int CW = 4;
  localparam int SW = 14;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [SW-1:0] game_score = '0;
  logic          force_light = 1'b0;
  logic [CW-1:0] old_r = '0, old_g = '0, old_b = '0;
  logic [CW-1:0] inv_r, inv_g, inv_b, inv_level;
  logic [CW-1:0] dim_r, dim_g, dim_b, dim_level;
  logic          inv_night, dim_night;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  day_night_fader #(
    .COLOR_W(CW), .SCORE_W(SW), .TRIGGER_PERIOD(700), .DARK_SPAN(150),
    .STEP_CYCLES(4), .MODE(FX_INVERT)
  ) dut_inv (
    .clk(clk), .rst(rst), .game_score(game_score), .force_light(force_light),
    .OldVgaRed(old_r), .OldVgaGreen(old_g), .OldVgaBlue(old_b),
    .NewVgaRed(inv_r), .NewVgaGreen(inv_g), .NewVgaBlue(inv_b),
    .level(inv_level), .is_night(inv_night)
  );

  day_night_fader #(
    .COLOR_W(CW), .SCORE_W(SW), .TRIGGER_PERIOD(700), .DARK_SPAN(150),
    .STEP_CYCLES(4), .MODE(FX_DIM)
  ) dut_dim (
    .clk(clk), .rst(rst), .game_score(game_score), .force_light(force_light),
    .OldVgaRed(old_r), .OldVgaGreen(old_g), .OldVgaBlue(old_b),
    .NewVgaRed(dim_r), .NewVgaGreen(dim_g), .NewVgaBlue(dim_b),
    .level(dim_level), .is_night(dim_night)
  );

  typedef struct {
    logic [CW-1:0] lvl;
    logic [CW-1:0] r, g, b;
    logic [CW-1:0] inv_r, inv_g, inv_b;
    logic [CW-1:0] dim_r, dim_g, dim_b;
  } px_vec_t;

  px_vec_t px_tab[5];

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Drive one table pixel at the current level and check both modes a clock later.
  task automatic apply_px(input int i);
    chk($sformatf("px%0d_level", i), int'(inv_level), int'(px_tab[i].lvl));
    old_r = px_tab[i].r;
    old_g = px_tab[i].g;
    old_b = px_tab[i].b;
    step(1);
    chk($sformatf("px%0d_inv_r", i), int'(inv_r), int'(px_tab[i].inv_r));
    chk($sformatf("px%0d_inv_g", i), int'(inv_g), int'(px_tab[i].inv_g));
    chk($sformatf("px%0d_inv_b", i), int'(inv_b), int'(px_tab[i].inv_b));
    chk($sformatf("px%0d_dim_r", i), int'(dim_r), int'(px_tab[i].dim_r));
    chk($sformatf("px%0d_dim_g", i), int'(dim_g), int'(px_tab[i].dim_g));
    chk($sformatf("px%0d_dim_b", i), int'(dim_b), int'(px_tab[i].dim_b));
  endtask

  task automatic wait_level(input string nm, input int target, input int budget);
    int n;
    n = 0;
    while (int'(inv_level) != target && n < budget) begin
      step(1);
      n++;
    end
    chk(nm, int'(inv_level), target);
  endtask

  task automatic wait_state(input string nm, input fade_state_t s, input int budget);
    int n;
    n = 0;
    while (dut_inv.state != s && n < budget) begin
      step(1);
      n++;
    end
    chk(nm, int'(dut_inv.state), int'(s));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int pend;

    //            lvl    r     g     b     inv_r inv_g inv_b dim_r dim_g dim_b
    px_tab[0] = '{4'h0, 4'h5, 4'hF, 4'h0, 4'h5, 4'hF, 4'h0, 4'h5, 4'hF, 4'h0};
    px_tab[1] = '{4'h0, 4'hC, 4'h1, 4'h7, 4'hC, 4'h1, 4'h7, 4'hC, 4'h1, 4'h7};
    px_tab[2] = '{4'hF, 4'h3, 4'h0, 4'hF, 4'hC, 4'hF, 4'h0, 4'h0, 4'h0, 4'h0};
    px_tab[3] = '{4'hF, 4'h8, 4'h7, 4'hE, 4'h7, 4'h8, 4'h1, 4'h0, 4'h0, 4'h0};
    px_tab[4] = '{4'h2, 4'h9, 4'h1, 4'h2, 4'h7, 4'h1, 4'h0, 4'h7, 4'h0, 4'h0};

    // Reset state.
    step(2);
    chk("rst_level", int'(inv_level), 0);
    chk("rst_new_r", int'(inv_r), 0);
    chk("rst_night", int'(inv_night), 0);
    rst = 1'b0;
    step(1);
    chk("idle_state", int'(dut_inv.state), int'(LIGHT));
    for (int i = 0; i < 2; i++) apply_px(i);

    // First night: 699 -> 700 triggers, then sixteen ticks to DARK.
    game_score = 14'd699;
    step(2);
    chk("pre_trig_night", int'(inv_night), 0);
    game_score = 14'd700;
    step(1);
    chk("trig_state", int'(dut_inv.state), int'(FADE_DARK));
    chk("trig_night", int'(inv_night), 1);
    chk("trig_level0", int'(inv_level), 0);
    wait_level("fade_first_inc", 1, 6);
    for (int v = 2; v <= 15; v++) begin
      step(4);
      chk($sformatf("fade_dark_l%0d", v), int'(inv_level), v);
    end
    step(4);
    chk("dark_state", int'(dut_inv.state), int'(DARK));
    chk("dark_level", int'(inv_level), 15);
    chk("dark_night", int'(inv_night), 1);
    chk("dim_night", int'(dim_night), 1);
    for (int i = 2; i < 4; i++) apply_px(i);
    chk("hold_no_trig", int'(dut_inv.trig), 0);

    // Expiry by a skipped score, then fade back to day.
    game_score = 14'd851;
    step(1);
    chk("exp_state", int'(dut_inv.state), int'(FADE_LIGHT));
    chk("exp_night", int'(inv_night), 0);
    wait_level("fade_first_dec", 14, 6);
    pend = 4;
    for (int v = 13; v >= 0; v--) begin
      step(pend);
      chk($sformatf("fade_light_l%0d", v), int'(inv_level), v);
      pend = 4;
      if (v == 2) begin
        apply_px(4);
        pend = 3;
      end
    end
    step(pend);
    chk("light_state", int'(dut_inv.state), int'(LIGHT));
    step(8);
    chk("light_no_wrap", int'(inv_level), 0);

    // Asynchronous reset in the middle of a fade at level 9.
    game_score = 14'd1400;
    wait_level("pre_rst_level", 9, 60);
    old_r = 4'h3; old_g = 4'h0; old_b = 4'h0;
    step(1);
    chk("pre_rst_px", int'(inv_r), 6);
    rst = 1'b1;
    #1;
    chk("arst_level", int'(inv_level), 0);
    chk("arst_new_r", int'(inv_r), 0);
    chk("arst_night", int'(inv_night), 0);
    chk("arst_dim_lvl", int'(dim_level), 0);
    game_score = '0;
    step(2);
    rst = 1'b0;
    #1;
    chk("rel_hold_r", int'(inv_r), 0);
    old_r = 4'hA; old_g = 4'hA; old_b = 4'hA;
    step(1);
    chk("rel_inv_r", int'(inv_r), 10);
    chk("rel_dim_b", int'(dim_b), 10);

    // A fall to score 0 is not a trigger.
    game_score = 14'd5;
    step(1);
    game_score = '0;
    step(1);
    chk("zero_no_trig", int'(inv_night), 0);
    chk("zero_state", int'(dut_inv.state), int'(LIGHT));

    // Second night; expiry exactly at DARK_SPAN, then reversal at level 6.
    game_score = 14'd699;
    step(1);
    game_score = 14'd700;
    step(1);
    chk("trig2_night", int'(inv_night), 1);
    wait_state("dark2", DARK, 90);
    game_score = 14'd849;
    step(3);
    chk("span_minus1", int'(dut_inv.state), int'(DARK));
    game_score = 14'd850;
    step(1);
    chk("span_exact", int'(dut_inv.state), int'(FADE_LIGHT));
    wait_level("rev_at6", 6, 50);
    game_score = 14'd1399;
    step(1);
    game_score = 14'd1400;
    step(1);
    chk("rev_state", int'(dut_inv.state), int'(FADE_DARK));
    chk("rev_night", int'(inv_night), 1);
    chk("rev_hold6", int'(inv_level), 6);
    step(2);
    chk("rev_l7", int'(inv_level), 7);
    step(4);
    chk("rev_l8", int'(inv_level), 8);

    // Restart via force_light, re-trigger from FADE_LIGHT, restart via score drop.
    wait_state("dark3", DARK, 60);
    force_light = 1'b1;
    step(1);
    force_light = 1'b0;
    chk("force_state", int'(dut_inv.state), int'(FADE_LIGHT));
    chk("force_night", int'(inv_night), 0);
    game_score = 14'd2100;
    step(1);
    chk("retrig_state", int'(dut_inv.state), int'(FADE_DARK));
    wait_state("dark4", DARK, 90);
    game_score = '0;
    step(1);
    chk("drop_state", int'(dut_inv.state), int'(FADE_LIGHT));
    chk("drop_night", int'(inv_night), 0);
    step(1);
    chk("drop_no_trig", int'(dut_inv.state), int'(FADE_LIGHT));
    wait_state("drop_light", LIGHT, 90);
    step(10);
    chk("final_level", int'(inv_level), 0);
    chk("final_night", int'(inv_night), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
